// File: rtl/grayscale_pipe_if.sv
// Pixel FIFO handshake bundle for grayscale_pipe: input-side pop,
// output-side push and the per-pixel conversion mode.
interface grayscale_pipe_if #(
    parameter int FIFO_DWIDTH_IN  = 24,
    parameter int FIFO_DWIDTH_OUT = 8
);
    logic                       mode;
    logic                       fifo_in_rd_en;
    logic [FIFO_DWIDTH_IN-1:0]  fifo_in_dout;
    logic                       fifo_in_empty;
    logic                       fifo_out_wr_en;
    logic [FIFO_DWIDTH_OUT-1:0] fifo_out_din;
    logic                       fifo_out_full;

    modport master (
        input  mode,
        input  fifo_in_dout,
        input  fifo_in_empty,
        input  fifo_out_full,
        output fifo_in_rd_en,
        output fifo_out_wr_en,
        output fifo_out_din
    );

    modport slave (
        output mode,
        output fifo_in_dout,
        output fifo_in_empty,
        output fifo_out_full,
        input  fifo_in_rd_en,
        input  fifo_out_wr_en,
        input  fifo_out_din
    );
endinterface

// File: rtl/grayscale_pipe.sv
// 3-stage RGB-to-gray pipeline (average or BT.601 luma) with full backpressure.
// Define GRAYSCALE_PIXCOUNT_EN to add the 32-bit pixel_count output.
module grayscale_pipe #(
    parameter int CH_WIDTH        = 8,
    parameter int FIFO_DWIDTH_IN  = 24,
    parameter int OUT_CHANNELS    = 1,
    parameter int FIFO_DWIDTH_OUT = 8
) (
    input  logic clock,
    input  logic reset,
    grayscale_pipe_if.master bus
`ifdef GRAYSCALE_PIXCOUNT_EN
    ,
    output logic [31:0] pixel_count
`endif
);
    localparam int W  = CH_WIDTH;
    localparam int SW = CH_WIDTH + 2;
    localparam int WW = CH_WIDTH + 8;

    if (FIFO_DWIDTH_IN != 3 * CH_WIDTH) begin : g_bad_in
        $error("FIFO_DWIDTH_IN must equal 3*CH_WIDTH");
    end
    if (FIFO_DWIDTH_OUT != OUT_CHANNELS * CH_WIDTH) begin : g_bad_out
        $error("FIFO_DWIDTH_OUT must equal OUT_CHANNELS*CH_WIDTH");
    end

    logic          v1, v2, v3;
    logic          m1, m2;
    logic [W-1:0]  r1, g1, b1;
    logic [WW-1:0] acc2;
    logic [W-1:0]  gray3;

    logic          en;
    logic [SW-1:0] sum;
    logic [WW-1:0] wsum;
    logic [SW-1:0] quot;
    logic [W-1:0]  gray_d;

    assign en = !(v3 && bus.fifo_out_full);

    assign bus.fifo_in_rd_en  = en && !bus.fifo_in_empty;
    assign bus.fifo_out_wr_en = v3 && !bus.fifo_out_full;
    assign bus.fifo_out_din   = {OUT_CHANNELS{gray3}};

    always_comb begin
        sum  = SW'(r1) + SW'(g1) + SW'(b1);
        wsum = WW'(r1) * WW'(77)
             + WW'(g1) * WW'(150)
             + WW'(b1) * WW'(29)
             + WW'(128);
    end

    // Constant divide keeps floor(sum/3) exact for the whole sum range.
    always_comb begin
        quot   = acc2[SW-1:0] / SW'(3);
        gray_d = m2 ? acc2[WW-1:8] : W'(quot);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            v1    <= 1'b0;
            m1    <= 1'b0;
            r1    <= '0;
            g1    <= '0;
            b1    <= '0;
            v2    <= 1'b0;
            m2    <= 1'b0;
            acc2  <= '0;
            v3    <= 1'b0;
            gray3 <= '0;
        end else if (en) begin
            v1    <= bus.fifo_in_rd_en;
            m1    <= bus.mode;
            r1    <= bus.fifo_in_dout[3*W-1:2*W];
            g1    <= bus.fifo_in_dout[2*W-1:W];
            b1    <= bus.fifo_in_dout[W-1:0];
            v2    <= v1;
            m2    <= m1;
            acc2  <= m1 ? wsum : WW'(sum);
            v3    <= v2;
            gray3 <= gray_d;
        end
    end

`ifdef GRAYSCALE_PIXCOUNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            pixel_count <= '0;
        end else if (bus.fifo_out_wr_en) begin
            pixel_count <= pixel_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_grayscale_pipe.sv
// Directed-vector bench for grayscale_pipe: single- and 3-channel
// instances driven by a modelled input FIFO and a checked output FIFO.
module tb_grayscale_pipe;
    logic clock = 1'b0;
    logic reset;
    logic mode;
    logic [23:0] din;
    logic empty;
    logic full;

    always #5 clock = ~clock;

    grayscale_pipe_if #(.FIFO_DWIDTH_IN(24), .FIFO_DWIDTH_OUT(8))  bus();
    grayscale_pipe_if #(.FIFO_DWIDTH_IN(24), .FIFO_DWIDTH_OUT(24)) bus3();

    assign bus.mode           = mode;
    assign bus.fifo_in_dout   = din;
    assign bus.fifo_in_empty  = empty;
    assign bus.fifo_out_full  = full;
    assign bus3.mode          = mode;
    assign bus3.fifo_in_dout  = din;
    assign bus3.fifo_in_empty = empty;
    assign bus3.fifo_out_full = full;

`ifdef GRAYSCALE_PIXCOUNT_EN
    logic [31:0] pc;
    logic [31:0] pc3;
`endif

    grayscale_pipe #(
        .CH_WIDTH(8), .FIFO_DWIDTH_IN(24),
        .OUT_CHANNELS(1), .FIFO_DWIDTH_OUT(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
`ifdef GRAYSCALE_PIXCOUNT_EN
        , .pixel_count(pc)
`endif
    );

    grayscale_pipe #(
        .CH_WIDTH(8), .FIFO_DWIDTH_IN(24),
        .OUT_CHANNELS(3), .FIFO_DWIDTH_OUT(24)
    ) dut3 (
        .clock(clock),
        .reset(reset),
        .bus(bus3)
`ifdef GRAYSCALE_PIXCOUNT_EN
        , .pixel_count(pc3)
`endif
    );

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       md;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        logic [23:0] rgb;
        logic        md;
        logic [7:0]  exp;
    } src_t;

    typedef struct {
        logic [7:0] exp;
        int         rcyc;
    } pipe_t;

    vec_t  vt[15];
    src_t  src_q[$];
    pipe_t pipe_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_cnt = 0;
    bit chk_lat = 1'b0;
    bit m1 = 1'b0, m2 = 1'b0, m3 = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic push_vec(input int i);
        src_t s;
        s.rgb = {vt[i].r, vt[i].g, vt[i].b};
        s.md  = vt[i].md;
        s.exp = vt[i].exp;
        src_q.push_back(s);
    endtask

    // Called at a negedge; covers one clock cycle ending at the next negedge.
    task automatic step(input bit gap, input bit full_v, input bit rst_v);
        pipe_t pe;
        bit    x_en, x_wr, x_rd;
        reset = rst_v;
        full  = full_v;
        empty = gap || (src_q.size() == 0);
        din   = (src_q.size() != 0) ? src_q[0].rgb : 24'h0;
        mode  = (src_q.size() != 0) ? src_q[0].md  : 1'b0;
        #1;
        x_en = !(m3 && full_v);
        x_wr = m3 && !full_v;
        x_rd = x_en && !empty;
        chk("rd_en", {31'd0, bus.fifo_in_rd_en}, {31'd0, x_rd});
        chk("wr_en", {31'd0, bus.fifo_out_wr_en}, {31'd0, x_wr});
        chk("wr_en3", {31'd0, bus3.fifo_out_wr_en}, {31'd0, x_wr});
        if (bus.fifo_out_wr_en === 1'b1) begin
            if (pipe_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_write: got %0h expected none (cycle %0d)",
                         bus.fifo_out_din, cyc);
            end else begin
                pe = pipe_q.pop_front();
                chk("dout", {24'd0, bus.fifo_out_din}, {24'd0, pe.exp});
                chk("dout3", {8'd0, bus3.fifo_out_din}, {8'd0, {3{pe.exp}}});
                if (chk_lat) chk("latency", cyc - pe.rcyc, 3);
                wr_cnt++;
            end
        end
        if (bus.fifo_in_rd_en === 1'b1 && src_q.size() != 0) begin
            pe.exp  = src_q[0].exp;
            pe.rcyc = cyc;
            pipe_q.push_back(pe);
            void'(src_q.pop_front());
        end
        if (rst_v) begin
            m1 = 1'b0;
            m2 = 1'b0;
            m3 = 1'b0;
            pipe_q.delete();
        end else if (x_en) begin
            m3 = m2;
            m2 = m1;
            m1 = x_rd;
        end
        cyc++;
        @(negedge clock);
    endtask

    task automatic drain(input bit gaps, input int flo, input int fhi);
        for (int c = 0; c < 200; c++) begin
            if (src_q.size() == 0 && pipe_q.size() == 0) break;
            step(gaps && c[0], (c >= flo) && (c < fhi), 1'b0);
        end
        chk("drained", src_q.size() + pipe_q.size(), 0);
    endtask

    int bl[8] = '{14, 4, 0, 5, 2, 6, 8, 11};
    int base;

    initial begin
        vt[0]  = '{8'd255, 8'd255, 8'd255, 1'b0, 8'd255};
        vt[1]  = '{8'd0,   8'd0,   8'd0,   1'b0, 8'd0};
        vt[2]  = '{8'd255, 8'd255, 8'd254, 1'b0, 8'd254};
        vt[3]  = '{8'd1,   8'd1,   8'd2,   1'b0, 8'd1};
        vt[4]  = '{8'd255, 8'd0,   8'd0,   1'b1, 8'd77};
        vt[5]  = '{8'd0,   8'd255, 8'd0,   1'b1, 8'd149};
        vt[6]  = '{8'd0,   8'd0,   8'd255, 1'b1, 8'd29};
        vt[7]  = '{8'd255, 8'd255, 8'd255, 1'b1, 8'd255};
        vt[8]  = '{8'd10,  8'd20,  8'd31,  1'b0, 8'd20};
        vt[9]  = '{8'd100, 8'd0,   8'd0,   1'b0, 8'd33};
        vt[10] = '{8'd100, 8'd50,  8'd200, 1'b1, 8'd82};
        vt[11] = '{8'd12,  8'd34,  8'd56,  1'b1, 8'd30};
        vt[12] = '{8'd12,  8'd34,  8'd56,  1'b0, 8'd34};
        vt[13] = '{8'd0,   8'd0,   8'd0,   1'b1, 8'd0};
        vt[14] = '{8'd255, 8'd0,   8'd0,   1'b0, 8'd85};

        reset = 1'b1;
        full  = 1'b0;
        empty = 1'b1;
        din   = 24'h0;
        mode  = 1'b0;
        repeat (3) @(negedge clock);

        // Idle after reset: nothing popped or pushed.
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);

        // Unstalled stream through every table vector.
        chk_lat = 1'b1;
        for (int i = 0; i < 15; i++) push_vec(i);
        base = wr_cnt;
        drain(1'b0, 0, 0);
        chk("stream_count", wr_cnt - base, 15);

        // Output backpressure: full for 5 cycles starting at cycle 4.
        chk_lat = 1'b0;
        for (int i = 0; i < 10; i++) push_vec(i);
        base = wr_cnt;
        drain(1'b0, 4, 9);
        chk("bp_count", wr_cnt - base, 10);

        // Empty and full together freeze the pipe.
        for (int i = 0; i < 3; i++) push_vec(i + 4);
        base = wr_cnt;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        drain(1'b0, 0, 0);
        chk("freeze_count", wr_cnt - base, 3);

        // Bursty input with per-pixel mode alternation.
        chk_lat = 1'b1;
        for (int i = 0; i < 8; i++) push_vec(bl[i]);
        base = wr_cnt;
        drain(1'b1, 0, 0);
        chk("burst_count", wr_cnt - base, 8);

        // Reset with three pixels held in flight.
        for (int i = 0; i < 3; i++) push_vec(i);
        base = wr_cnt;
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
        chk("reset_flush", wr_cnt - base, 0);
        push_vec(10);
        drain(1'b0, 0, 0);
        chk("post_reset_count", wr_cnt - base, 1);

`ifdef GRAYSCALE_PIXCOUNT_EN
        force dut.pixel_count = 32'hFFFF_FFFE;
        #1;
        release dut.pixel_count;
        for (int i = 0; i < 3; i++) push_vec(i);
        drain(1'b0, 0, 0);
        chk("pixel_count_wrap", pc, 32'h0000_0001);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
